bdpsk_phase_gen: RTL and testbench
==================================

// Module: bdpsk_phase_gen
// PURPOSE
//  Upstream address generator for the BDPSK sine lookup table (128 x 8-bit, 7-bit address).
//  Accepts a serial data-bit stream through a valid/ready handshake and differentially
//  encodes it (d_k = d_(k-1) XOR b_k). Runs a phase accumulator NCO.
//  Emits one registered 7-bit LUT address per clock; d=1 adds a pi (+64) offset.
// PARAMETERS
//  PHASE_W  16   phase accumulator width (bits), >= 7
//  FCW      512  frequency control word added per sample (512 -> 1 LUT step per clk at PHASE_W=16)
//  SPS      128  samples (clocks) per symbol, >= 2
// PORTS
//  clk            in   1        system clock, rising edge
//  reset_n        in   1        asynchronous reset, active low
//  enable         in   1        run request; sampled only at symbol boundaries
//  bit_in         in   1        data bit
//  bit_valid      in   1        bit_in valid
//  bit_ready      out  1        hold register empty (= ~hold_full)
//  address        out  7        LUT address, registered
//  addr_valid     out  1        address carries a modulated sample
//  symbol_strobe  out  1        1-clk pulse aligned with the first sample of each symbol
//  underrun       out  1        1-clk pulse: symbol started with no bit available
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, acc=0, d=0, sym_cnt=0, hold_full=0.
//   Outputs: address=0, addr_valid=0, symbol_strobe=0, underrun=0; bit_ready=1.
//  Handshake: the bit is accepted when bit_valid & bit_ready. It goes into the 1-entry hold register.
//   The bit is retained across IDLE and is lost only on reset.
//  Load event: one of:
//   - IDLE with enable=1; or
//   - RUN with sym_cnt==0 and enable=1.
//  On a load event, select the symbol bit b:
//   - hold_full=1: b = hold; hold_full<=0.
//   - hold empty and bit_valid=1 this cycle: bypass, b = bit_in; the bit is consumed and not stored.
//   - otherwise: b = 0 and underrun<=1. Phase is unchanged (no transition).
//   After selecting b: d <= d ^ b; symbol_strobe<=1.
//  States:
//   IDLE -> RUN on the load event.
//   RUN -> IDLE when sym_cnt==0 and enable=0.
//    That cycle: addr_valid<=0, address<=0, acc<=0, d<=0.
//    enable falling mid-symbol completes the current symbol.
//  Per RUN/load cycle:
//   - address <= acc[PHASE_W-1 -: 7] + {d_new,6'b0}, mod 128 (d_new = updated d on load events, else d).
//   - addr_valid<=1.
//   - acc <= acc + FCW, mod 2^PHASE_W.
//   - sym_cnt <= (sym_cnt==SPS-1) ? 0 : sym_cnt+1.
//  acc is continuous across symbols (coherent carrier). It is cleared only in IDLE.
//  Latency: enable=1 sampled in IDLE -> addr_valid=1 and first address on the next clock.
//  symbol_strobe/underrun are registered, coincident with the symbol's first address.
//  Wrap: 7-bit add drops the carry (e.g. 100+64 -> 36).
// STRUCTURE
//  Package bdpsk_pkg: ADDR_W=7, PI_OFFSET=7'd64, state enum {IDLE,RUN}.
//  Sub-module bdpsk_nco_acc: accumulator with clear/advance, outputs acc[PHASE_W-1 -: 7].
//  FSM, hold register, differential encoder and sym_cnt ($clog2(SPS) bits) live in the top.
// TESTING (PHASE_W=16, FCW=512, SPS=128 unless noted)
//  1 Reset mid-RUN (reset_n low at sample 40).
//    -> address=0, addr_valid=0, strobes 0 immediately.
//    -> After release: IDLE, bit_ready=1, held bit discarded.
//  2 Bits 1,0,1,1 preloaded in time, enable held.
//    -> Symbol-start addresses 64,64,0,64; addresses step +1 mod 128 within each symbol.
//    -> 4 symbol_strobe pulses, 128 clks apart.
//  3 No bit offered before the 2nd boundary.
//    -> underrun=1 for 1 clk.
//    -> Address continues 127->0 with no +64 jump.
//  4 Hold empty; bit_valid=1, bit_in=1 exactly on the boundary cycle.
//    -> Bit consumed via bypass: underrun=0, offset toggles at that symbol start, hold stays empty.
//  5 enable dropped at sample 10 of a symbol.
//    -> 118 more valid samples, then addr_valid=0, address=0.
//    -> A pending held bit is retained; bit_ready stays 0.
//  6 FCW=64, SPS=4, d=1, acc top=126.
//    -> Next address (126+64)&127 = 62.
//    -> Accumulator wraps 0xFFC0->0x0000 without glitch.

Source files
------------

// File: rtl/bdpsk_pkg.sv
// Shared constants and types for the BDPSK phase/address generator.
package bdpsk_pkg;

  // Sine LUT is 128 entries, so addresses are 7 bits wide.
  localparam int ADDR_W = 7;

  // Half a LUT period: adding this to the address is a pi phase shift.
  localparam logic [ADDR_W-1:0] PI_OFFSET = 7'd64;

  // Top-level control state.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Apply the differential-symbol phase offset. The 7-bit add drops the carry,
  // which is exactly the modulo-128 wrap the LUT needs.
  function automatic logic [ADDR_W-1:0] pi_shift(input logic [ADDR_W-1:0] base,
                                                 input logic              d_sym);
    return base + (d_sym ? PI_OFFSET : '0);
  endfunction

endpackage

// File: rtl/bdpsk_nco_acc.sv
// Phase accumulator for the carrier NCO. Exposes only the top ADDR_W bits,
// which index the sine LUT directly.
module bdpsk_nco_acc
  import bdpsk_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int FCW     = 512
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] phase_top
);

  localparam logic [PHASE_W-1:0] STEP = PHASE_W'(FCW);

  logic [PHASE_W-1:0] acc;

  // Clear has priority so the carrier always restarts at phase 0 from IDLE;
  // otherwise the accumulator free-runs modulo 2^PHASE_W across symbols.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (advance) begin
      acc <= acc + STEP;
    end
  end

  assign phase_top = acc[PHASE_W-1 -: ADDR_W];

endmodule

// File: rtl/bdpsk_phase_gen.sv
// BDPSK sine-LUT address generator: takes a serial bit stream over a
// valid/ready handshake, differentially encodes it, and emits one registered
// LUT address per clock from a coherent NCO, adding a pi offset when the
// encoded symbol is 1.
module bdpsk_phase_gen
  import bdpsk_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int FCW     = 512,
  parameter int SPS     = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [ADDR_W-1:0] address,
  output logic              addr_valid,
  output logic              symbol_strobe,
  output logic              underrun
);

  localparam int             CNT_W   = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SPS - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   sym_cnt;
  logic               hold_full;
  logic               hold_bit;
  logic               d;

  logic               at_bound;
  logic               load;
  logic               stop;
  logic               running;
  logic               bypass;
  logic               store_bit;
  logic               sym_bit;
  logic               d_new;
  logic [ADDR_W-1:0]  phase_top;

  // Symbol-boundary decode and bit selection for the differential encoder.
  always_comb begin
    at_bound  = (sym_cnt == '0);
    load      = enable & ((state == IDLE) | ((state == RUN) & at_bound));
    stop      = (state == RUN) & at_bound & ~enable;
    running   = load | ((state == RUN) & ~at_bound);
    // A bit arriving on the boundary with an empty hold register is used
    // directly rather than stored, so it costs no extra symbol of latency.
    bypass    = load & ~hold_full & bit_valid;
    store_bit = bit_valid & ~hold_full & ~load;
    sym_bit   = 1'b0;
    if (hold_full) begin
      sym_bit = hold_bit;
    end else if (bypass) begin
      sym_bit = bit_in;
    end
    d_new     = load ? (d ^ sym_bit) : d;
  end

  assign bit_ready = ~hold_full;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: start on a load, stop only at a symbol boundary so a symbol
  // in flight always completes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = RUN;
      RUN:     if (stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One-entry hold register; its contents survive IDLE and are only lost on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full <= 1'b0;
      hold_bit  <= 1'b0;
    end else if (load && hold_full) begin
      hold_full <= 1'b0;
    end else if (store_bit) begin
      hold_full <= 1'b1;
      hold_bit  <= bit_in;
    end
  end

  // Differential encoder state; returns to 0 whenever the block goes idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d <= 1'b0;
    end else if (stop) begin
      d <= 1'b0;
    end else if (load) begin
      d <= d_new;
    end
  end

  // Samples-per-symbol counter; zero marks the next symbol boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sym_cnt <= '0;
    end else if (running) begin
      sym_cnt <= (sym_cnt == CNT_MAX) ? '0 : sym_cnt + 1'b1;
    end else begin
      sym_cnt <= '0;
    end
  end

  // Carrier phase: held at zero while idle, advancing every active sample.
  bdpsk_nco_acc #(
    .PHASE_W (PHASE_W),
    .FCW     (FCW)
  ) u_nco (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (~running),
    .advance   (running),
    .phase_top (phase_top)
  );

  // Registered outputs; strobes line up with the first address of a symbol.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      address       <= '0;
      addr_valid    <= 1'b0;
      symbol_strobe <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      if (running) begin
        address    <= pi_shift(phase_top, d_new);
        addr_valid <= 1'b1;
      end else begin
        address    <= '0;
        addr_valid <= 1'b0;
      end
      symbol_strobe <= load;
      underrun      <= load & ~hold_full & ~bit_valid;
    end
  end

endmodule

// File: tb/tb_bdpsk_phase_gen.sv
// Self-checking bench for bdpsk_phase_gen: a symbol table drives the main
// sequence, expected samples flow through a scoreboard queue, and hand-written
// sequences cover reset mid-run and a small-FCW/short-symbol accumulator wrap.
module tb_bdpsk_phase_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;
  logic       bit_ready, addr_valid, symbol_strobe, underrun;
  logic [6:0] address;

  logic       en6 = 1'b0, bi6 = 1'b0, bv6 = 1'b0;
  logic       rdy6, av6, strb6, und6;
  logic [6:0] addr6;

  always #5 clk = ~clk;

  bdpsk_phase_gen #(.PHASE_W(16), .FCW(512), .SPS(128)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bit_in(bit_in),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .address(address),
    .addr_valid(addr_valid), .symbol_strobe(symbol_strobe), .underrun(underrun)
  );

  bdpsk_phase_gen #(.PHASE_W(16), .FCW(64), .SPS(4)) dut6 (
    .clk(clk), .reset_n(reset_n), .enable(en6), .bit_in(bi6),
    .bit_valid(bv6), .bit_ready(rdy6), .address(addr6),
    .addr_valid(av6), .symbol_strobe(strb6), .underrun(und6)
  );

  typedef struct {
    logic       av;
    logic [6:0] addr;
    logic       strb;
    logic       und;
  } exp_t;

  // src: 0 = no bit (underrun), 1 = from hold register, 2 = bypass on boundary
  typedef struct {
    int         src;
    logic       b;
    logic       offer_v;
    logic       offer_b;
    int         drop_at;
    logic [6:0] exp_start;
    logic       exp_und;
  } vec_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic av, input logic [6:0] a, input logic s, input logic u);
    exp_t e;
    e.av = av; e.addr = a; e.strb = s; e.und = u;
    q.push_back(e);
  endtask

  task automatic pop_cmp(input string nm, input logic av, input logic [6:0] a,
                         input logic s, input logic u);
    exp_t e;
    if (q.size() == 0) begin
      chk({nm, " scoreboard empty"}, 1, 0);
      return;
    end
    e = q.pop_front();
    chk({nm, " addr_valid"}, av, e.av);
    if (e.av) chk({nm, " address"}, a, e.addr);
    else      chk({nm, " idle address"}, a, e.addr);
    chk({nm, " symbol_strobe"}, s, e.strb);
    chk({nm, " underrun"}, u, e.und);
  endtask

  // One clock on the main DUT: drive, push expected, edge, sample 1 ns later.
  task automatic step(input string nm, input logic en, input logic bv, input logic bi,
                      input logic eav, input logic [6:0] ea, input logic es, input logic eu);
    enable = en; bit_valid = bv; bit_in = bi;
    push(eav, ea, es, eu);
    @(posedge clk);
    #1;
    pop_cmp(nm, addr_valid, address, symbol_strobe, underrun);
  endtask

  task automatic step6(input string nm, input logic en, input logic bv, input logic bi,
                       input logic eav, input logic [6:0] ea, input logic es, input logic eu);
    en6 = en; bv6 = bv; bi6 = bi;
    push(eav, ea, es, eu);
    @(posedge clk);
    #1;
    pop_cmp(nm, av6, addr6, strb6, und6);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[8];
    logic en_run;
    logic [6:0] a;

    // Symbol table: d sequence 1,1,0,1,0,0(underrun),1(bypass),1; acc top is 0
    // at every boundary since each symbol advances exactly one LUT period.
    tbl[0] = '{1, 1'b1, 1'b1, 1'b0, 999, 7'd64, 1'b0};
    tbl[1] = '{1, 1'b0, 1'b1, 1'b1, 999, 7'd64, 1'b0};
    tbl[2] = '{1, 1'b1, 1'b1, 1'b1, 999, 7'd0,  1'b0};
    tbl[3] = '{1, 1'b1, 1'b1, 1'b1, 999, 7'd64, 1'b0};
    tbl[4] = '{1, 1'b1, 1'b0, 1'b0, 999, 7'd0,  1'b0};
    tbl[5] = '{0, 1'b0, 1'b0, 1'b0, 999, 7'd0,  1'b1};
    tbl[6] = '{2, 1'b1, 1'b1, 1'b0, 999, 7'd64, 1'b0};
    tbl[7] = '{1, 1'b0, 1'b1, 1'b1, 10,  7'd64, 1'b0};

    // Reset state
    #12;
    chk("reset address", address, 0);
    chk("reset addr_valid", addr_valid, 0);
    chk("reset symbol_strobe", symbol_strobe, 0);
    chk("reset underrun", underrun, 0);
    chk("reset bit_ready", bit_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);

    // Preload first bit while idle; it must stay held and not start anything.
    step("preload", 1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0);
    chk("preload bit_ready", bit_ready, 0);

    en_run = 1'b1;
    for (int j = 0; j < 8; j++) begin
      for (int s = 0; s < 128; s++) begin
        logic bv, bi;
        bv = 1'b0; bi = 1'b0;
        if (s == 0 && tbl[j].src == 2) begin bv = 1'b1; bi = tbl[j].b; end
        if (s == 5 && tbl[j].offer_v)  begin bv = 1'b1; bi = tbl[j].offer_b; end
        if (s >= tbl[j].drop_at) en_run = 1'b0;
        a = tbl[j].exp_start + 7'(s);
        step($sformatf("sym%0d s%0d", j, s), en_run, bv, bi,
             1'b1, a, (s == 0), (s == 0) && tbl[j].exp_und);
        if (s == 1) chk($sformatf("sym%0d ready after load", j), bit_ready, 1);
        if (s == 6 && tbl[j].offer_v) chk($sformatf("sym%0d ready after offer", j), bit_ready, 0);
      end
    end

    // Symbol completed after mid-symbol enable drop: block goes idle, bit kept.
    step("stop", 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
    step("stop idle", 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
    chk("held bit retained", bit_ready, 0);

    // Restart from the retained bit (d was cleared, held bit 1 -> offset on).
    for (int s = 0; s < 40; s++) begin
      step($sformatf("restart s%0d", s), 1'b1, (s == 5), 1'b1,
           1'b1, 7'd64 + 7'(s), (s == 0), 1'b0);
    end
    chk("restart hold full", bit_ready, 0);

    // Asynchronous reset in the middle of the clock period.
    #2 reset_n = 1'b0;
    #1;
    chk("async rst address", address, 0);
    chk("async rst addr_valid", addr_valid, 0);
    chk("async rst symbol_strobe", symbol_strobe, 0);
    chk("async rst underrun", underrun, 0);
    chk("async rst bit_ready", bit_ready, 1);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++)
      step("post rst idle", 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
    chk("post rst bit_ready", bit_ready, 1);
    // Held bit was discarded: starting now underruns with no offset.
    for (int s = 0; s < 4; s++)
      step($sformatf("post rst s%0d", s), 1'b1, 1'b0, 1'b0,
           1'b1, 7'(s), (s == 0), (s == 0));
    enable = 1'b0;

    // FCW=64, SPS=4: eight samples per LUT step; d stays 1 after the first
    // symbol because every later boundary underruns.
    step6("w idle", 1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0);
    for (int n = 0; n < 1040; n++) begin
      a = 7'((n / 8) + 64);
      step6($sformatf("w n%0d", n), 1'b1, 1'b0, 1'b0,
            1'b1, a, (n % 4 == 0), (n % 4 == 0) && (n != 0));
      if (n == 1008) chk("acc top 126 plus pi", addr6, 62);
      if (n == 1023) chk("acc 0xFFC0 sample", addr6, 63);
      if (n == 1024) chk("acc wrap to 0", addr6, 64);
    end

    chk("scoreboard drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
